// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART transmitter.
// Parity selectors, FSM state encoding and the baud divider helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_tx_state_t;

  // Rounded clocks-per-bit.
  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready word handshake for the UART transmitter.
// The producer is master; the transmitter FIFO is slave.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered level and full flag.
// Head word is readable the cycle after it is written.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_n;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & (cnt != '0);

  always_comb begin
    cnt_n = cnt;
    if (do_push & ~do_pop)
      cnt_n = cnt + 1'b1;
    else if (~do_push & do_pop)
      cnt_n = cnt - 1'b1;
  end

  // Held full during reset so nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full_q <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt    <= cnt_n;
      full_q <= (cnt_n == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = (cnt == '0);
  assign level   = cnt;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: TX FIFO, baud counter and framing FSM.
// Configurable data bits, parity and stop bits; registered line output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        RST_clk,
  input  logic                        RST_n,
  uart_tx_fifo_if.slave               tx,
  output logic                        uart_tx_data,
  output logic                        uart_busy,
  output logic                        uart_clk_tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          SB_LAST  = 1'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 >= 2");
  end

  logic [DATA_BITS-1:0] rd_data;
  logic                 full;
  logic                 empty;
  logic                 pop;

  uart_sync_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (RST_clk),
    .rst     (RST_n),
    .push    (tx.tx_valid),
    .pop     (pop),
    .wr_data (tx.tx_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign tx.tx_ready = ~full;

  uart_tx_state_t       state_q;
  uart_tx_state_t       state_n;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_n;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_n;
  logic                 sb_q;
  logic                 sb_n;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 tick;
  logic                 line_c;
  logic                 line_q;
  logic                 busy_q;
  logic                 tick_q;

  assign tick = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    sb_n    = sb_q;
    pop     = 1'b0;
    line_c  = 1'b1;
    cnt_n   = (state_q == ST_IDLE || tick) ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        line_c = 1'b0;
        if (tick) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        line_c = shreg_q[idx_q];
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            sb_n    = 1'b0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        line_c = par_q;
        if (tick) begin
          state_n = ST_STOP;
          sb_n    = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sb_q == SB_LAST) begin
            // Chain straight into the next frame when data is waiting.
            if (!empty) begin
              pop     = 1'b1;
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            sb_n = sb_q + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge RST_clk) begin
    if (RST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sb_q    <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sb_q    <= sb_n;
      line_q  <= line_c;
      busy_q  <= (state_q != ST_IDLE) || !empty;
      tick_q  <= tick;
    end
  end

  always_ff @(posedge RST_clk) begin
    if (pop) begin
      shreg_q <= rd_data;
      par_q   <= (PARITY == PAR_ODD) ? ~^rd_data : ^rd_data;
    end
  end

  assign uart_tx_data = line_q;
  assign uart_busy    = busy_q;
  assign uart_clk_tx  = tick_q;

endmodule
